// File: rtl/kb_uart_bridge.sv
// kb_uart_bridge: captures one keyboard character per key_valid rising edge into a FIFO
// and drains it back-to-back through a UART transmitter with configurable frame format.
module kb_uart_bridge #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       key_in,
  input  logic             key_valid,
  input  logic             clr_overflow,
  output logic             tx,
  output logic             tx_busy,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow
);

  localparam int                DEPTH     = 1 << FIFO_AW;
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic              PAR_INV   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [BAUD_W-1:0]    r_baud;
  logic [BAUD_W-1:0]    w_baud_next;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_next;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_tx;
  logic                 r_busy;
  logic                 w_tx_next;
  logic                 r_kv_q;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wptr;
  logic [FIFO_AW-1:0]   r_rptr;
  logic [FIFO_AW:0]     r_count;
  logic [FIFO_AW:0]     w_count_next;
  logic                 r_overflow;
  logic                 w_push;
  logic                 w_push_ok;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_has_data;
  logic                 w_baud_last;
  logic                 w_parity;
  logic                 w_key_unused;

  // Upper key bits are ignored for narrow frames.
  assign w_key_unused = ^key_in;

  assign w_push      = key_valid & ~r_kv_q;
  assign w_full      = r_count[FIFO_AW];
  assign w_has_data  = (r_count != '0);
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_parity    = (^r_data) ^ PAR_INV;

  // Reset value 1 keeps a level held across reset release from pushing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kv_q <= 1'b1;
    end else begin
      r_kv_q <= key_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= key_in[DATA_BITS-1:0];
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push_ok && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud + 1'b1;
    w_bit_next   = r_bit;
    w_pop        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_bit_next  = '0;
        if (w_has_data) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit == DATA_LAST) begin
            w_bit_next   = '0;
            w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit == STOP_LAST) begin
            w_bit_next = '0;
            // Chain straight into the next start bit when more data waits.
            if (w_has_data) begin
              w_pop        = 1'b1;
              w_state_next = S_START;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
        w_bit_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_data[w_bit_next];
      S_PARITY: w_tx_next = w_parity;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      if (w_pop) begin
        r_data <= r_mem[r_rptr];
      end
      r_tx   <= w_tx_next;
      r_busy <= (w_state_next != S_IDLE);
    end
  end

  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_kb_uart_bridge.sv
// Scoreboard bench: stimulus queues expected line frames, per-DUT monitors decode tx and compare.
`timescale 1ns/1ps
module tb_kb_uart_bridge;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] key_in = 8'h00;
  logic       key_valid = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] key_in_p = 8'h00;
  logic       kv_p = 1'b0;
  logic [2:0] w_tx;
  logic [2:0] w_busy;
  logic [4:0] cnt, cnt_e, cnt_o;
  logic       ovf, ovf_e, ovf_o;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int b2b0 = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];

  always #5 clk = ~clk;

  kb_uart_bridge #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(4)) u_dut (
    .clk(clk), .reset(rst_n), .key_in(key_in), .key_valid(key_valid), .clr_overflow(clr_ovf),
    .tx(w_tx[0]), .tx_busy(w_busy[0]), .fifo_count(cnt), .overflow(ovf));

  kb_uart_bridge #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_AW(4)) u_even (
    .clk(clk), .reset(rst_n), .key_in(key_in_p), .key_valid(kv_p), .clr_overflow(1'b0),
    .tx(w_tx[1]), .tx_busy(w_busy[1]), .fifo_count(cnt_e), .overflow(ovf_e));

  kb_uart_bridge #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_AW(4)) u_odd (
    .clk(clk), .reset(rst_n), .key_in(key_in_p), .key_valid(kv_p), .clr_overflow(1'b0),
    .tx(w_tx[2]), .tx_busy(w_busy[2]), .fifo_count(cnt_o), .overflow(ovf_o));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
  endtask

  // Decodes one frame of nb bits (bit i = i-th bit on the line) and scores it.
  task automatic monitor(input int idx, input int nb);
    logic [15:0] got;
    logic [15:0] want;
    bit stable, busy_ok, aborted, have_start, found;
    have_start = 0;
    forever begin
      if (!have_start) @(negedge clk);
      have_start = 0;
      if (rst_n && w_tx[idx] == 1'b0) begin
        got = '0; stable = 1; busy_ok = 1; aborted = 0;
        for (int b = 0; b < nb && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (!rst_n) aborted = 1;
            else begin
              if (c == 0) got[b] = w_tx[idx];
              else if (w_tx[idx] != got[b]) stable = 0;
              if (!w_busy[idx]) busy_ok = 0;
              @(negedge clk);
            end
          end
        end
        if (!aborted && rst_n) begin
          have_start = (w_tx[idx] == 1'b0);
          if (have_start && idx == 0) b2b0++;
          found = 0; want = '0;
          case (idx)
            0: if (exp_q0.size() > 0) begin want = exp_q0.pop_front(); found = 1; end
            1: if (exp_q1.size() > 0) begin want = exp_q1.pop_front(); found = 1; end
            default: if (exp_q2.size() > 0) begin want = exp_q2.pop_front(); found = 1; end
          endcase
          if (!found) begin
            chk_cnt++;
            $display("FAIL unexpected_frame tx%0d: got 0x%0h, required no frame", idx, got);
          end else begin
            check($sformatf("frame_tx%0d", idx), {16'h0, got}, {16'h0, want});
            check($sformatf("frame_stable_busy_tx%0d", idx), {30'h0, stable, busy_ok}, 32'h3);
          end
        end
      end
    end
  endtask

  initial monitor(0, 10);
  initial monitor(1, 11);
  initial monitor(2, 11);

  task automatic push(input logic [7:0] d, input bit expect_frame);
    key_in = d; key_valid = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0;
    if (expect_frame) exp_q0.push_back({6'b0, 1'b1, d, 1'b0});
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((w_busy[0] || cnt != 0) && n < max_cyc) begin
      @(posedge clk); #1; n++;
    end
    check(name, {26'h0, w_busy[0], cnt}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0; key_valid = 1'b1; key_in = 8'h77;
    repeat (3) @(posedge clk); #1;
    check("rst_tx", w_tx[0], 1); check("rst_busy", w_busy[0], 0);
    check("rst_cnt", cnt, 0); check("rst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("held_across_reset_cnt", cnt, 0); check("held_across_reset_busy", w_busy[0], 0);
    key_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single character 0x41, 8N1
    key_in = 8'h41; key_valid = 1'b1; exp_q0.push_back(16'h0282);
    @(posedge clk); #1 key_valid = 1'b0;
    check("push_cnt", cnt, 1); check("push_tx_idle", w_tx[0], 1);
    @(posedge clk); #1;
    check("start_tx", w_tx[0], 0); check("start_busy", w_busy[0], 1); check("pop_cnt", cnt, 0);
    n = 1;
    while (w_busy[0] && n < 200) begin
      @(posedge clk); #1;
      if (w_busy[0]) n++;
    end
    check("busy_len", n, 40);
    check("single_end_cnt", cnt, 0);
    repeat (2) @(posedge clk); #1;

    // Held valid: one push only
    key_in = 8'h55; key_valid = 1'b1; exp_q0.push_back(16'h02AA);
    repeat (100) @(posedge clk); #1 key_valid = 1'b0;
    wait_drain("held_drain", 200);

    // Overflow: 18 pushes, the last one dropped
    b2b0 = 0;
    for (int i = 0; i < 18; i++) push(8'(i), i < 17);
    check("ovf_set", ovf, 1); check("ovf_full_cnt", cnt, 16);
    wait_drain("ovf_drain", 1000);
    check("no_gaps", b2b0, 16); check("ovf_sticky", ovf, 1);
    clr_ovf = 1'b1; @(posedge clk); #1 clr_ovf = 1'b0;
    check("ovf_clr", ovf, 0);
    repeat (2) @(posedge clk); #1;

    // Full FIFO with push on the STOP->START pop edge
    key_in = 8'hA0; key_valid = 1'b1; exp_q0.push_back({6'b0, 1'b1, 8'hA0, 1'b0});
    @(posedge clk); #1 key_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) push(8'hA0 + 8'(i), 1'b1);
    repeat (7) @(posedge clk); #1;
    check("full_cnt", cnt, 16); check("full_ovf_pre", ovf, 0);
    key_in = 8'hB1; key_valid = 1'b1; exp_q0.push_back({6'b0, 1'b1, 8'hB1, 1'b0});
    @(posedge clk); #1 key_valid = 1'b0;
    check("pushpop_cnt", cnt, 16); check("pushpop_ovf", ovf, 0); check("pushpop_start", w_tx[0], 0);
    wait_drain("full_drain", 1200);

    // Parity: 7 data bits, 2 stop bits, 0x41
    key_in_p = 8'h41; kv_p = 1'b1;
    exp_q1.push_back(16'b110_1000_0010);
    exp_q2.push_back(16'b111_1000_0010);
    @(posedge clk); #1 kv_p = 1'b0;
    repeat (60) @(posedge clk); #1;
    check("par_idle", w_busy[2:1], 0);

    // Reset during data bit 3 with three entries queued
    key_in = 8'hC3; key_valid = 1'b1; exp_q0.push_back({6'b0, 1'b1, 8'hC3, 1'b0});
    @(posedge clk); #1 key_valid = 1'b0;
    @(posedge clk); #1;
    push(8'hC4, 1'b1); push(8'hC5, 1'b1); push(8'hC6, 1'b1);
    repeat (10) @(posedge clk); #2;
    check("bit3_tx", w_tx[0], 0); check("queued_cnt", cnt, 3);
    rst_n = 1'b0; #1;
    check("rst_async_tx", w_tx[0], 1); check("rst_async_busy", w_busy[0], 0);
    check("rst_async_cnt", cnt, 0);
    exp_q0.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("post_rst_cnt", cnt, 0); check("post_rst_busy", w_busy[0], 0);
    check("post_rst_tx", w_tx[0], 1);
    check("queues_empty", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/kb_uart_bridge.md
# kb_uart_bridge

Buffered, parametrised keyboard-to-serial bridge. It sits between the PS/2 keyboard decoder (ASCII byte plus done/valid level) and the board's serial TX pin. Each rising edge of the keyboard valid signal captures one character into a FIFO. A built-in UART transmitter drains the FIFO back-to-back with configurable baud, data width, parity and stop bits, so fast typing no longer loses characters mid-frame.

## Interface
Parameters:
- CLKS_PER_BIT, 10416: clk cycles per serial bit (100 MHz / 9600 baud); must be ≥ 2.
- DATA_BITS, 8: data bits per frame, 5..8; uses key_in[DATA_BITS-1:0].
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW (default 16).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_in  in  8  character from the keyboard decoder.
- key_valid  in  1  keyboard done level; each 0→1 transition pushes key_in.
- clr_overflow  in  1  synchronous clear of overflow.
- tx  out  1  serial line, idles high.
- tx_busy  out  1  high while a frame is on the line.
- fifo_count  out  FIFO_AW+1  entries currently stored.
- overflow  out  1  sticky; a push was dropped because the FIFO was full.

## Operation
- Reset (reset=0) is asynchronous. It forces tx=1, tx_busy=0, fifo_count=0, overflow=0, FSM=IDLE and the pointers to 0. The internal key_valid_q register is forced to 1.
- Edge detect: push = key_valid & ~key_valid_q, with key_valid_q registered every cycle. A level held high across reset release does not push until it falls and rises again.
- Push writes key_in[DATA_BITS-1:0] at the write pointer. Pointers wrap modulo 2^FIFO_AW.
- Push when full and no pop in the same cycle: data is dropped, overflow sets, count is unchanged.
- Push and pop in the same cycle: both are accepted (including when full or empty-with-pop-impossible), and count is unchanged. A push to an empty FIFO is never popped in the same cycle.
- overflow: a set event has priority over clr_overflow in the same cycle.
- TX FSM states: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE/START.
  - IDLE: tx=1. If fifo_count>0, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: LSB first, DATA_BITS bits, each for CLKS_PER_BIT cycles.
  - PARITY: odd parity gives ^data ^ 1; even parity gives ^data.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On its last cycle, if fifo_count>0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- tx_busy=1 in every state except IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and resets on every state entry. The bit index counts 0..DATA_BITS-1.

## Timing
- tx, tx_busy, fifo_count and overflow are all registered outputs.
- Push sampled at edge N gives fifo_count+1 visible after edge N.
- The IDLE pop happens at edge N+1, where tx falls and tx_busy rises. fifo_count returns to its previous value at the same edge.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exactly.
- Back-to-back frames have zero idle cycles between the last stop cycle and the next start bit.
- Reset mid-frame: tx goes high immediately and asynchronously, the frame is aborted and the FIFO is flushed. No partial frame resumes after release.
- Throughput limit: one character per frame time. Sustained input faster than this fills the FIFO and then sets overflow.

## Test plan
- **Single character**, CLKS_PER_BIT=4, 8N1: key_in=0x41 with a key_valid rise → tx low 1 cycle after the push edge. Line reads 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles, for 40 cycles total. tx_busy is high for exactly 40 cycles and fifo_count ends at 0.
- **Held valid**: key_valid high for 100 cycles with key_in=0x55 → exactly one frame and one push. Also: key_valid high across reset release → no frame.
- **Overflow**, FIFO_AW=4, CLKS_PER_BIT=4: 18 pushes of 0x00..0x11, one every 2 cycles → 0x00 is popped immediately, 0x01..0x10 fill 16 entries, 0x11 is dropped. overflow=1. 17 frames 0x00..0x10 are sent in order with no gaps. clr_overflow then gives overflow=0.
- **Full with simultaneous push/pop**: fill to 16 entries, then push on the STOP→START pop cycle → push accepted, fifo_count stays 16, no overflow.
- **Parity/width**, DATA_BITS=7, STOP_BITS=2, 0x41: PARITY=2 gives parity bit 0; PARITY=1 gives parity bit 1. Frame is 11 bits with a 2-bit high stop.
- **Reset mid-frame**: assert reset during DATA bit 3 with 3 entries queued → tx=1 within the same cycle. After release, fifo_count=0, tx_busy=0 and no further frames.
